// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: op codes, datapath width and the idle select value.
package alu_ctrl_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    LSL = 4'd4,
    CMP = 4'd5,
    SET = 4'd6,
    LDR = 4'd7,
    STR = 4'd8,
    B   = 4'd9,
    BEQ = 4'd10,
    BGE = 4'd11,
    NOP = 4'd15
  } alu_op_e;

  // The ALU outputs zero for this select, so an idle issue stage keeps it quiet.
  localparam logic [3:0] ALU_SEL_IDLE = 4'hF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starts at the pointer.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] eligible,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;

  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == N_REQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin issue register,
// per-requester response registers and the architectural Z flag written by CMP.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*4-1:0]     req_op,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ*WIDTH-1:0] rsp_data,
  output logic [N_REQ-1:0]       rsp_zero,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  output logic                   flag_z,
  output logic                   busy
);

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             issue_valid;
  logic [IDW-1:0]   issue_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic [IDW-1:0]   sel_id;

  // A requester may only have one op in flight; popping its response frees it the same cycle.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign eligible[gi] = req_valid[gi]
                        & ~(issue_valid & (issue_id == IDW'(gi)))
                        & (~rsp_valid[gi] | rsp_ready[gi]);
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant & {N_REQ{rst_n}};

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_a  = req_a[k*WIDTH +: WIDTH];
        sel_b  = req_b[k*WIDTH +: WIDTH];
        sel_op = req_op[k*4 +: 4];
        sel_id = IDW'(k);
      end
    end
  end

  // Operands hold when idle so the ALU inputs do not toggle; only the select goes idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_id    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
    end else begin
      issue_valid <= |grant;
      alu_sel     <= (|grant) ? sel_op : ALU_SEL_IDLE;
      if (|grant) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        issue_id <= sel_id;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             zero_reg;
    logic             write;

    assign write = issue_valid & (issue_id == IDW'(gi));

    // A landing result wins over a pop at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        zero_reg  <= 1'b0;
      end else if (write) begin
        valid_reg <= 1'b1;
        data_reg  <= alu_result;
        zero_reg  <= alu_zero;
      end else if (rsp_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign rsp_valid[gi]                 = valid_reg;
    assign rsp_data[gi*WIDTH +: WIDTH]   = data_reg;
    assign rsp_zero[gi]                  = zero_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
    end else if (issue_valid && (alu_sel == CMP)) begin
      flag_z <= alu_zero;
    end
  end

  assign busy = issue_valid | (|rsp_valid);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (32-bit A/B, 4-bit sel, zero flag) between N_REQ requesters, e.g. the scalar pipe and the vector/DMA address unit.
- Round-robin grant, valid/ready handshake on requests and responses, and a two-stage operand/result pipeline around the ALU.
- Maintains the architectural Z flag, written only by CMP, which the branch unit reads for BEQ/BGE.
- Sits between the decode/issue logic and the ALU instance in the Execute stage.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- N_REQ, 2, number of requesters; legal range 2..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero).
- req_a  in  N_REQ*WIDTH  operand A; requester i in slice i.
- req_b  in  N_REQ*WIDTH  operand B; requester i in slice i.
- req_op  in  N_REQ*4  ALU op code (alu_op_e); requester i in slice i.
- rsp_valid  out  N_REQ  result available for requester i.
- rsp_ready  in  N_REQ  requester i consumes its result.
- rsp_data  out  N_REQ*WIDTH  result; requester i in slice i.
- rsp_zero  out  N_REQ  ALU zero flag captured with the result.
- alu_a  out  WIDTH  to ALU input A.
- alu_b  out  WIDTH  to ALU input B.
- alu_sel  out  4  to ALU op select.
- alu_result  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.
- flag_z  out  1  architectural Z flag, updated by CMP only.
- busy  out  1  issue stage valid, or any rsp_valid set.

Behaviour:
- Reset (async assert, sync-released deassert): req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, flag_z=0, busy=0, RR pointer=0, issue stage empty, alu_a/alu_b/alu_sel=0.
- Eligibility of requester i:
  - req_valid[i]=1;
  - no op for i in the issue stage;
  - rsp_valid[i]=0, or rsp_valid[i]&rsp_ready[i] in the same cycle.
  - Result: at most one outstanding op per requester, no response overwrite.
- Grant:
  - round-robin among eligible requesters, starting from the RR pointer.
  - req_ready = grant, at most one hot. Ready may depend on valid; valid must not depend on ready.
  - On grant, the pointer moves to (granted+1) mod N_REQ; otherwise it holds.
- Stage 1 (grant edge T): latch A, B, op and requester id into the issue register; issue_valid=1.
- Stage 2 (cycle T+1):
  - alu_a/alu_b/alu_sel are driven directly from the issue register.
  - At the T+1 edge, alu_result and alu_zero are written to rsp_data[id]/rsp_zero[id], and rsp_valid[id]=1.
  - Response is visible in cycle T+2. Fixed latency: accept-to-rsp_valid = 2 cycles.
- Throughput: one grant per cycle when requesters differ. The same requester can re-issue in the cycle its response is popped, i.e. once per 2 cycles minimum.
- rsp_valid[i] clears at the edge where rsp_valid[i]&rsp_ready[i], unless a new result for i is written at the same edge; in that case it stays 1 with new data.
- rsp_data/rsp_zero hold stable while rsp_valid=1 and rsp_ready=0.
- flag_z: at the stage-2 edge with op==CMP (4'b0101), flag_z <= alu_zero. All other ops leave flag_z unchanged. CMP also returns the difference on rsp_data.
- Ops 4'b1100..4'b1111 are forwarded unchanged; the ALU returns 0, so rsp_zero=1. Not an error.
- When the issue stage is empty, alu_sel is driven with 4'b1111 (ALU default, output 0) and alu_a/alu_b hold their last values, so the ALU never toggles needlessly.
- Reset asserted mid-operation: in-flight and pending responses are discarded, and flag_z returns to 0.

Decomposition:
- Package alu_ctrl_pkg:
  - alu_op_e enum: ADD=0, SUB=1, AND=2, OR=3, LSL=4, CMP=5, SET=6, LDR=7, STR=8, B=9, BEQ=10, BGE=11, NOP=15.
  - ALU_W=32 and the ALU_SEL_IDLE constant.
- Sub-module rr_arbiter (N_REQ, eligible vector in, one-hot grant out, pointer register inside); also reusable for the memory port.

Test Plan:
- Single requester: req0 ADD A=5, B=7 accepted at T -> rsp_valid[0] at T+2, rsp_data=12, rsp_zero=0, flag_z unchanged (0).
- CMP flags: req1 CMP A=9, B=9 -> rsp_data=0, rsp_zero=1, flag_z=1. Then req1 SUB A=3, B=3 -> flag_z stays 1. Then CMP A=4, B=3 -> flag_z=0.
- Round-robin: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1. Each response carries its own operands: req0 ADD 1+1=2, req1 LSL 1<<4=16.
- Backpressure: req0 result pending with rsp_ready[0]=0 for 5 cycles -> req_ready[0]=0 throughout, rsp_data held. req1 continues to be granted every cycle its slot frees.
- Simultaneous pop and write: rsp_ready[0] asserted in the cycle a new req0 result lands -> rsp_valid[0] stays 1, data switches to the new value, no lost or duplicated response.
- Reset mid-flight: rst_n low while the issue stage is valid and rsp_valid=2'b11 -> all outputs 0 immediately (asynchronous). After release, the first grant goes to req0.
